tc_to_binary_pipe: RTL and testbench
====================================

# tc_to_binary_pipe

Parametrised, pipelined successor of the modulus-9 thermometer-to-binary decoder used at the output of the RNS modulo adders. Converts an (M-1)-bit LSB-first thermometer-coded residue to a ceil(log2(M))-bit binary residue for any modulus M. Adds a valid/ready handshake, a two-stage pipeline, code-legality checking with a per-result error flag, a strict/bubble-tolerant mode, and a saturating error counter. Sits between the thermometer-domain residue adders and the binary reverse converter.

## Interface
- M, default 9: modulus; legal range 3..64.
- MODE, default 0: 0 = strict (illegal code → result 0); 1 = bubble-tolerant (illegal code → popcount).
- CNT_W, default 8: error-counter width.
- Derived: TW = M-1 (code width), BW = $clog2(M) (result width).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input code presented.
- in_ready  out  1  block can accept input this cycle.
- in_code  in  TW  thermometer code, bit 0 = first "1".
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_bin  out  BW  binary residue 0..M-1.
- out_err  out  1  result came from an illegal code.
- err_clr  in  1  synchronous clear of err_cnt.
- err_cnt  out  CNT_W  saturating count of accepted illegal codes.

## Operation
- Legal codes: all-zero (value 0) and k contiguous ones from bit 0, k = 1..TW (value k). Anything else is illegal.
- Strict mode: legal → k; illegal → 0 with out_err = 1. For M = 9, this matches the existing decoder bit-for-bit on out_bin.
- Bubble mode: out_bin = popcount(in_code), at most TW; out_err = 1 when illegal.
- Stage 1 (S1) registers in_code and a legality bit. Stage 2 (S2) registers out_bin/out_err from the S1 contents.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- S2 can load when !out_valid | out_ready.
- S1 can load when !s1_valid | S2 can load.
- in_ready equals the S1 load condition. The combinational out_ready→in_ready path is accepted; there is no skid buffer.
- Data in a stalled stage holds stable. out_bin and out_err do not change while out_valid & !out_ready.
- err_cnt increments by 1 when an illegal code is accepted (input transfer with illegal code). It saturates at 2^CNT_W-1.
- err_clr in the same cycle as an increment: clear wins, err_cnt = 0 next cycle.
- in_code is ignored when in_valid = 0. It does not affect err_cnt.

## Timing
- Reset (async assert, sync release) values: in_ready = 1, out_valid = 0, out_bin = 0, out_err = 0, err_cnt = 0, both stage valid bits 0.
- Latency: 2 cycles. A code accepted at edge n appears with out_valid = 1 after edge n+1 and is consumable at edge n+2.
- Throughput: 1 result/cycle while out_ready = 1.
- Order preserved; no drop and no duplication under any out_ready pattern.
- Full: both stages valid and out_ready = 0 → in_ready = 0.
- out_ready = 1 with both stages valid → simultaneous shift, so in_ready = 1 that cycle.
- Reset mid-operation: in-flight results are discarded, no output transfer occurs, and err_cnt → 0.

## Structure
- Package tc_pkg:
  - function tc_is_legal(code, tw)
  - function tc_popcount(code, tw)
  - function tc_first_zero(code, tw) for the strict decode
  - enum tc_mode_e {TC_STRICT, TC_BUBBLE}
- One combinational sub-module, tc_decode_core (params M, MODE): inputs code; outputs bin, err. Instantiated between S1 and S2.
- Pipeline registers, handshake and counter live in the top.

## Test plan
- M=9, MODE=0, out_ready=1: stream 8'h00, 8'h01, 8'h07, 8'hFF → out_bin 0, 1, 3, 8, out_err 0, each 2 cycles after accept, back-to-back.
- M=9, MODE=0: 8'h05, 8'h80 → out_bin 0, out_err 1; err_cnt = 2.
- M=9, MODE=1: 8'h0B → out_bin 3, out_err 1; 8'h3F → 6, out_err 0.
- Backpressure: out_ready = 0 for 5 cycles with 4 codes offered → exactly 2 accepted and in_ready = 0. Release → results in order, none lost, outputs stable while stalled.
- Counter: CNT_W=2, 5 illegal codes → err_cnt holds 3. err_clr asserted together with a 6th illegal accept → err_cnt = 0.
- M=5 (TW=4, BW=3) and M=17 (TW=16, BW=5): all legal codes decode to k. rst_n pulsed low mid-stream → out_valid drops immediately, err_cnt = 0, in_ready = 1.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared types and helpers for thermometer-to-binary residue decoding.
// Codes are LSB-first thermometer vectors of width tw (at most 63 bits).
package tc_pkg;

    typedef enum logic {
        TC_STRICT = 1'b0,
        TC_BUBBLE = 1'b1
    } tc_mode_e;

    // Mask selecting the low tw bits of a 64-bit container.
    function automatic logic [63:0] tc_mask(input int tw);
        logic [63:0] m;
        if (tw >= 64) begin
            m = '1;
        end else begin
            m = (64'd1 << tw) - 64'd1;
        end
        return m;
    endfunction

    // Legal codes are all-zero or a run of ones starting at bit 0.
    // A run of low ones plus one carries into a single clean bit, so the
    // AND with the incremented value is zero exactly for legal codes.
    function automatic logic tc_is_legal(input logic [63:0] code, input int tw);
        logic [63:0] c;
        c = code & tc_mask(tw);
        return ((c & (c + 64'd1)) == 64'd0) && (c == code);
    endfunction

    // Number of ones among the low tw bits.
    function automatic logic [6:0] tc_popcount(input logic [63:0] code, input int tw);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < tw) begin
                cnt = cnt + {6'd0, code[i]};
            end
        end
        return cnt;
    endfunction

    // Index of the lowest zero bit; tw when all tw bits are set.
    // For a legal code this is exactly the number of ones.
    function automatic logic [6:0] tc_first_zero(input logic [63:0] code, input int tw);
        logic [6:0] idx;
        logic       found;
        idx   = 7'(tw);
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if ((i < tw) && !found && !code[i]) begin
                idx   = 7'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tc_decode_core.sv
// Combinational decode of a registered thermometer code into a binary
// residue. The legality bit arrives precomputed from the first stage so
// the check is not duplicated here.
module tc_decode_core
    import tc_pkg::*;
#(
    parameter int M    = 9,
    parameter int MODE = 0,
    localparam int TW  = M - 1,
    localparam int BW  = $clog2(M)
) (
    input  logic [TW-1:0] code,
    input  logic          legal,
    output logic [BW-1:0] bin,
    output logic          err
);

    localparam tc_mode_e DEC_MODE = (MODE == 1) ? TC_BUBBLE : TC_STRICT;

    // Strict mode forces illegal codes to 0; bubble mode counts the ones.
    // Both results are at most TW, which always fits in BW bits.
    always_comb begin
        bin = '0;
        err = ~legal;
        if (DEC_MODE == TC_BUBBLE) begin
            bin = BW'(tc_popcount(64'(code), TW));
        end else if (legal) begin
            bin = BW'(tc_first_zero(64'(code), TW));
        end
    end

endmodule

// File: rtl/tc_to_binary_pipe.sv
// Two-stage pipelined thermometer-to-binary residue decoder with a
// valid/ready handshake and a saturating count of accepted illegal codes.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its data stable until the transfer;
// ready may depend combinationally on the downstream ready (no skid buffer).
module tc_to_binary_pipe
    import tc_pkg::*;
#(
    parameter int M     = 9,
    parameter int MODE  = 0,
    parameter int CNT_W = 8,
    localparam int TW   = M - 1,
    localparam int BW   = $clog2(M)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TW-1:0]    in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BW-1:0]    out_bin,
    output logic             out_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Stage 1: raw code plus its legality bit.
    logic          s1_valid_q, s1_valid_d;
    logic [TW-1:0] s1_code_q, s1_code_d;
    logic          s1_legal_q, s1_legal_d;

    // Stage 2: decoded result, which is also the output register.
    logic          out_valid_q, out_valid_d;
    logic [BW-1:0] out_bin_q, out_bin_d;
    logic          out_err_q, out_err_d;

    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic          in_legal;
    logic          s2_load;
    logic          s1_load;
    logic          in_fire;
    logic [BW-1:0] dec_bin;
    logic          dec_err;

    // Legality of the incoming code, used for stage 1 and for the counter.
    always_comb begin
        in_legal = tc_is_legal(64'(in_code), TW);
    end

    // Load conditions: a stage may take new data when empty or when the
    // stage after it is moving in the same cycle.
    always_comb begin
        s2_load = ~out_valid_q | out_ready;
        s1_load = ~s1_valid_q | s2_load;
        in_fire = in_valid & s1_load;
    end

    tc_decode_core #(
        .M    (M),
        .MODE (MODE)
    ) u_core (
        .code  (s1_code_q),
        .legal (s1_legal_q),
        .bin   (dec_bin),
        .err   (dec_err)
    );

    // Next-state for both pipeline stages; stalled stages keep their data.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_code_d   = s1_code_q;
        s1_legal_d  = s1_legal_q;
        out_valid_d = out_valid_q;
        out_bin_d   = out_bin_q;
        out_err_d   = out_err_q;

        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_code_d  = in_code;
                s1_legal_d = in_legal;
            end
        end

        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_bin_d = dec_bin;
                out_err_d = dec_err;
            end
        end
    end

    // Error counter: clear has priority over a same-cycle increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (in_fire && !in_legal && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_code_q   <= '0;
            s1_legal_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_code_q   <= s1_code_d;
            s1_legal_q  <= s1_legal_d;
            out_valid_q <= out_valid_d;
            out_bin_q   <= out_bin_d;
            out_err_q   <= out_err_d;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign in_ready  = s1_load;
    assign out_valid = out_valid_q;
    assign out_bin   = out_bin_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_tc_to_binary_pipe.sv
// Directed bench for tc_to_binary_pipe: strict and bubble decoding at M=9,
// backpressure, counter saturation/clear, M=5 and M=17 sweeps, async reset.
module tb_tc_to_binary_pipe;

    logic clk;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;

    logic [4:0]  exp_q[$];
    logic [31:0] tmp;

    // M=9 strict, 2-bit counter
    logic       a_valid, a_ready, a_ovalid, a_oready, a_err, a_clr;
    logic [7:0] a_code;
    logic [3:0] a_bin;
    logic [1:0] a_cnt;
    // M=9 bubble
    logic       b_valid, b_ready, b_ovalid, b_oready, b_err, b_clr;
    logic [7:0] b_code;
    logic [3:0] b_bin;
    logic [7:0] b_cnt;
    // M=5 strict
    logic       c_valid, c_ready, c_ovalid, c_oready, c_err, c_clr;
    logic [3:0] c_code;
    logic [2:0] c_bin;
    logic [7:0] c_cnt;
    // M=17 strict
    logic        d_valid, d_ready, d_ovalid, d_oready, d_err, d_clr;
    logic [15:0] d_code;
    logic [4:0]  d_bin;
    logic [7:0]  d_cnt;

    tc_to_binary_pipe #(.M(9), .MODE(0), .CNT_W(2)) u9s (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
        .in_code(a_code), .out_valid(a_ovalid), .out_ready(a_oready),
        .out_bin(a_bin), .out_err(a_err), .err_clr(a_clr), .err_cnt(a_cnt)
    );
    tc_to_binary_pipe #(.M(9), .MODE(1), .CNT_W(8)) u9b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
        .in_code(b_code), .out_valid(b_ovalid), .out_ready(b_oready),
        .out_bin(b_bin), .out_err(b_err), .err_clr(b_clr), .err_cnt(b_cnt)
    );
    tc_to_binary_pipe #(.M(5), .MODE(0), .CNT_W(8)) u5 (
        .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(c_ready),
        .in_code(c_code), .out_valid(c_ovalid), .out_ready(c_oready),
        .out_bin(c_bin), .out_err(c_err), .err_clr(c_clr), .err_cnt(c_cnt)
    );
    tc_to_binary_pipe #(.M(17), .MODE(0), .CNT_W(8)) u17 (
        .clk(clk), .rst_n(rst_n), .in_valid(d_valid), .in_ready(d_ready),
        .in_code(d_code), .out_valid(d_ovalid), .out_ready(d_oready),
        .out_bin(d_bin), .out_err(d_err), .err_clr(d_clr), .err_cnt(d_cnt)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for the M=9 strict instance: every output transfer must
    // match the next expected {err, bin} in acceptance order.
    always @(negedge clk) begin
        if (rst_n && a_ovalid && a_oready) begin
            if (exp_q.size() == 0) begin
                chk("a_unexpected_output", 32'(a_bin), 32'hFFFF_FFFF);
            end else begin
                chk("a_scoreboard", 32'({a_err, a_bin}), 32'(exp_q.pop_front()));
                n_pops++;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        a_valid = 0; a_code = '0; a_oready = 1; a_clr = 0;
        b_valid = 0; b_code = '0; b_oready = 1; b_clr = 0;
        c_valid = 0; c_code = '0; c_oready = 1; c_clr = 0;
        d_valid = 0; d_code = '0; d_oready = 1; d_clr = 0;

        tick();
        tick();
        chk("rst_in_ready", 32'(a_ready), 32'd1);
        chk("rst_out_valid", 32'(a_ovalid), 32'd0);
        chk("rst_out_bin", 32'(a_bin), 32'd0);
        chk("rst_out_err", 32'(a_err), 32'd0);
        chk("rst_err_cnt", 32'(a_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Legal stream, back-to-back, 2-cycle latency
        a_valid = 1; a_code = 8'h00; exp_q.push_back(5'h00);
        tick();
        chk("s1_valid_early", 32'(a_ovalid), 32'd0);
        a_code = 8'h01; exp_q.push_back(5'h01);
        tick();
        chk("s1_v0", 32'(a_ovalid), 32'd1);
        chk("s1_b0", 32'(a_bin), 32'd0);
        chk("s1_e0", 32'(a_err), 32'd0);
        a_code = 8'h07; exp_q.push_back(5'h03);
        tick();
        chk("s1_b1", 32'(a_bin), 32'd1);
        a_code = 8'hFF; exp_q.push_back(5'h08);
        tick();
        chk("s1_b3", 32'(a_bin), 32'd3);
        a_valid = 0;
        tick();
        chk("s1_v8", 32'(a_ovalid), 32'd1);
        chk("s1_b8", 32'(a_bin), 32'd8);
        chk("s1_e8", 32'(a_err), 32'd0);
        tick();
        chk("s1_drained", 32'(a_ovalid), 32'd0);

        // Illegal codes in strict mode
        a_valid = 1; a_code = 8'h05; exp_q.push_back(5'h10);
        tick();
        a_code = 8'h80; exp_q.push_back(5'h10);
        tick();
        chk("ill_b05", 32'({a_err, a_bin}), 32'h10);
        chk("ill_cnt2", 32'(a_cnt), 32'd2);
        a_valid = 0;
        tick();
        chk("ill_b80", 32'({a_err, a_bin}), 32'h10);
        tick();
        tick();

        // Bubble mode
        b_valid = 1; b_code = 8'h0B;
        tick();
        b_code = 8'h3F;
        tick();
        chk("bub_0b_bin", 32'(b_bin), 32'd3);
        chk("bub_0b_err", 32'(b_err), 32'd1);
        b_valid = 0;
        tick();
        chk("bub_3f_bin", 32'(b_bin), 32'd6);
        chk("bub_3f_err", 32'(b_err), 32'd0);
        chk("bub_cnt", 32'(b_cnt), 32'd1);
        tick();

        // Backpressure: 5 stalled edges, 4 codes offered, 2 accepted
        a_oready = 0;
        a_valid = 1; a_code = 8'h01; exp_q.push_back(5'h01);
        #1 chk("bp_ready0", 32'(a_ready), 32'd1);
        tick();
        a_code = 8'h03; exp_q.push_back(5'h02);
        #1 chk("bp_ready1", 32'(a_ready), 32'd1);
        tick();
        a_code = 8'h07;
        #1 chk("bp_full", 32'(a_ready), 32'd0);
        chk("bp_ovalid", 32'(a_ovalid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_stall_ready", 32'(a_ready), 32'd0);
            chk("bp_stall_bin", 32'({a_err, a_bin}), 32'h01);
            chk("bp_stall_valid", 32'(a_ovalid), 32'd1);
        end
        a_oready = 1; exp_q.push_back(5'h03);
        #1 chk("bp_shift_ready", 32'(a_ready), 32'd1);
        tick();
        chk("bp_next_bin", 32'(a_bin), 32'd2);
        a_code = 8'h0F; exp_q.push_back(5'h04);
        tick();
        a_valid = 0;
        tick();
        tick();
        tick();
        chk("bp_drained", 32'(a_ovalid), 32'd0);

        // Counter saturation and clear priority (2-bit counter)
        a_clr = 1;
        tick();
        a_clr = 0;
        chk("cnt_cleared", 32'(a_cnt), 32'd0);
        a_valid = 1; a_code = 8'h05;
        exp_q.push_back(5'h10);
        tick();
        chk("cnt_1", 32'(a_cnt), 32'd1);
        exp_q.push_back(5'h10);
        tick();
        chk("cnt_2", 32'(a_cnt), 32'd2);
        exp_q.push_back(5'h10);
        tick();
        chk("cnt_3", 32'(a_cnt), 32'd3);
        exp_q.push_back(5'h10);
        tick();
        chk("cnt_sat4", 32'(a_cnt), 32'd3);
        exp_q.push_back(5'h10);
        tick();
        chk("cnt_sat5", 32'(a_cnt), 32'd3);
        a_clr = 1; exp_q.push_back(5'h10);
        tick();
        chk("cnt_clr_wins", 32'(a_cnt), 32'd0);
        a_clr = 0; a_valid = 0; a_code = 8'hAA;
        tick();
        chk("cnt_idle_ignored", 32'(a_cnt), 32'd0);
        tick();
        tick();

        // M=5: every legal code decodes to its run length
        for (int k = 0; k <= 5; k++) begin
            if (k <= 4) begin
                c_valid = 1;
                tmp = (32'd1 << k) - 32'd1;
                c_code = tmp[3:0];
            end else begin
                c_valid = 0;
            end
            tick();
            if (k >= 1) begin
                chk("m5_valid", 32'(c_ovalid), 32'd1);
                chk("m5_bin", 32'(c_bin), 32'(k - 1));
                chk("m5_err", 32'(c_err), 32'd0);
            end
        end
        tick();
        chk("m5_drained", 32'(c_ovalid), 32'd0);

        // M=17: every legal code decodes to its run length
        for (int k = 0; k <= 17; k++) begin
            if (k <= 16) begin
                d_valid = 1;
                tmp = (32'd1 << k) - 32'd1;
                d_code = tmp[15:0];
            end else begin
                d_valid = 0;
            end
            tick();
            if (k >= 1) begin
                chk("m17_valid", 32'(d_ovalid), 32'd1);
                chk("m17_bin", 32'(d_bin), 32'(k - 1));
                chk("m17_err", 32'(d_err), 32'd0);
            end
        end
        tick();

        // Reset mid-stream on M=17
        d_valid = 1; d_code = 16'h0101;
        tick();
        chk("m17_cnt1", 32'(d_cnt), 32'd1);
        d_code = 16'h0003;
        tick();
        chk("m17_ill_bin", 32'({d_err, d_bin}), 32'h20);
        d_code = 16'h000F;
        #1 chk("m17_shift_ready", 32'(d_ready), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ovalid", 32'(d_ovalid), 32'd0);
        chk("mid_rst_cnt", 32'(d_cnt), 32'd0);
        chk("mid_rst_ready", 32'(d_ready), 32'd1);
        chk("mid_rst_bin", 32'(d_bin), 32'd0);
        d_valid = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_ovalid", 32'(d_ovalid), 32'd0);
        chk("post_rst_cnt", 32'(d_cnt), 32'd0);
        d_valid = 1; d_code = 16'h0007;
        tick();
        d_valid = 0;
        tick();
        chk("post_rst_bin", 32'(d_bin), 32'd3);
        chk("post_rst_valid", 32'(d_ovalid), 32'd1);
        tick();

        // Scoreboard completeness
        chk("a_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("a_pop_count", 32'(n_pops), 32'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
